// File: rtl/gcd_unit_if.sv
// ============================================================================
// Module   : gcd_unit_if
// Brief    : Command/result handshake bundle between a requester and gcd_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface gcd_unit_if #(
    parameter int WIDTH    = 8,
    parameter int MAX_ITER = 255
);
    localparam int CW = $clog2(MAX_ITER + 1);

    logic             go;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             ack;
    logic             abort;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] gcd_out;
    logic [CW-1:0]    iter_cnt;
    logic             err;

    modport master (
        output go, a_in, b_in, ack, abort,
        input  ready, valid, gcd_out, iter_cnt, err
    );

    modport slave (
        input  go, a_in, b_in, ack, abort,
        output ready, valid, gcd_out, iter_cnt, err
    );
endinterface

`default_nettype wire

// File: rtl/gcd_unit.sv
// ============================================================================
// Module   : gcd_unit
// Brief    : Iterative subtraction GCD engine with iteration cap and abort.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gcd_unit #(
    parameter int WIDTH    = 8,
    parameter int MAX_ITER = 255
) (
    input  wire logic  clk,
    input  wire logic  clr_n,
    gcd_unit_if.slave  bus
);
    localparam int            CW           = $clog2(MAX_ITER + 1);
    localparam logic [CW-1:0] c_iter_limit = CW'(MAX_ITER);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_gcd;
    logic [CW-1:0]    r_cnt;
    logic             r_err;
    logic [WIDTH-1:0] w_x_nxt;
    logic [WIDTH-1:0] w_y_nxt;
    logic [WIDTH-1:0] w_gcd_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_err_nxt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_gcd   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_gcd   <= w_gcd_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_gcd_nxt   = r_gcd;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;

        case (r_state)
            S_IDLE: begin
                if (!bus.abort && bus.go) begin
                    w_x_nxt     = bus.a_in;
                    w_y_nxt     = bus.b_in;
                    w_gcd_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_CALC;
                end
            end

            S_CALC: begin
                // Priority order matters: zero/equal termination is checked
                // before the iteration cap so a finished result is never lost.
                if (bus.abort) begin
                    w_gcd_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if ((r_x == '0) || (r_y == '0)) begin
                    w_gcd_nxt   = r_x | r_y;
                    w_err_nxt   = (r_x == '0) && (r_y == '0);
                    w_state_nxt = S_DONE;
                end else if (r_x == r_y) begin
                    w_gcd_nxt   = r_x;
                    w_state_nxt = S_DONE;
                end else if (r_cnt == c_iter_limit) begin
                    w_gcd_nxt   = '0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_x < r_y) begin
                    w_y_nxt   = r_y - r_x;
                    w_cnt_nxt = r_cnt + CW'(1);
                end else begin
                    w_x_nxt   = r_x - r_y;
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            S_DONE: begin
                if (bus.ack || bus.abort) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.ready    = (r_state == S_IDLE);
    assign bus.valid    = (r_state == S_DONE);
    assign bus.gcd_out  = r_gcd;
    assign bus.iter_cnt = r_cnt;
    assign bus.err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_gcd_unit.sv
// ============================================================================
// Module   : tb_gcd_unit
// Brief    : Directed self-checking bench for gcd_unit (default and capped builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gcd_unit;
    logic clk = 1'b0;
    logic clr_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    gcd_unit_if #(.WIDTH(8), .MAX_ITER(255)) bus  ();
    gcd_unit_if #(.WIDTH(8), .MAX_ITER(4))   bus4 ();

    gcd_unit #(.WIDTH(8), .MAX_ITER(255)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    gcd_unit #(.WIDTH(8), .MAX_ITER(4)) dut4 (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus4)
    );

    // Operands are scrambled right after acceptance so a late-sampling DUT shows up.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.a_in = a;
        bus.b_in = b;
        bus.go   = 1'b1;
        @(posedge clk);
        #1;
        bus.go   = 1'b0;
        bus.a_in = 8'($urandom);
        bus.b_in = 8'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (bus.valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        bus.ack = 1'b1;
        @(posedge clk);
        #1;
        bus.ack = 1'b0;
    endtask

    function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return 8'(x);
    endfunction

    task automatic test_reset();
        clr_n = 1'b0;
        bus.go = 1'b1; bus.a_in = 8'd9; bus.b_in = 8'd6;
        bus.ack = 1'b0; bus.abort = 1'b0;
        bus4.go = 1'b0; bus4.a_in = '0; bus4.b_in = '0;
        bus4.ack = 1'b0; bus4.abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.ready !== 1'b1 || bus.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_handshake: ready=%b valid=%b, expected ready=1 valid=0", bus.ready, bus.valid);
        end
        n_cmp++;
        if (bus.gcd_out !== 8'd0 || bus.iter_cnt !== 8'd0 || bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: gcd=%0d cnt=%0d err=%b, expected 0/0/0", bus.gcd_out, bus.iter_cnt, bus.err);
        end
        @(negedge clk);
        bus.go = 1'b0;
        clr_n  = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        start_op(8'd12, 8'd18);
        wait_valid(lat);
        n_cmp++;
        if (lat != 3) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d edges, expected 3", lat);
        end
        n_cmp++;
        if (bus.gcd_out !== 8'd6 || bus.iter_cnt !== 8'd2 || bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_result: gcd=%0d cnt=%0d err=%b, expected 6/2/0", bus.gcd_out, bus.iter_cnt, bus.err);
        end
        do_ack();
        n_cmp++;
        if (bus.ready !== 1'b1 || bus.valid !== 1'b0 || bus.gcd_out !== 8'd6 || bus.iter_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL basic_after_ack: ready=%b valid=%b gcd=%0d cnt=%0d, expected 1/0/6/2",
                     bus.ready, bus.valid, bus.gcd_out, bus.iter_cnt);
        end
    endtask

    task automatic test_zero();
        int lat;
        start_op(8'd0, 8'd45);
        wait_valid(lat);
        n_cmp++;
        if (lat != 1 || bus.gcd_out !== 8'd45 || bus.iter_cnt !== 8'd0 || bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_a: lat=%0d gcd=%0d cnt=%0d err=%b, expected 1/45/0/0",
                     lat, bus.gcd_out, bus.iter_cnt, bus.err);
        end
        do_ack();
        start_op(8'd0, 8'd0);
        wait_valid(lat);
        n_cmp++;
        if (lat != 1 || bus.gcd_out !== 8'd0 || bus.err !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_both: lat=%0d gcd=%0d err=%b, expected 1/0/1", lat, bus.gcd_out, bus.err);
        end
        do_ack();
    endtask

    task automatic test_vectors();
        logic [7:0] va [6] = '{8'd48, 8'd17, 8'd7, 8'd255, 8'd1,   8'd45};
        logic [7:0] vb [6] = '{8'd36, 8'd5,  8'd7, 8'd1,   8'd255, 8'd0};
        logic [7:0] vg [6] = '{8'd12, 8'd1,  8'd7, 8'd1,   8'd1,   8'd45};
        logic [7:0] vc [6] = '{8'd3,  8'd6,  8'd0, 8'd254, 8'd254, 8'd0};
        int lat;
        for (int i = 0; i < 6; i++) begin
            start_op(va[i], vb[i]);
            wait_valid(lat);
            n_cmp++;
            if (lat != int'(vc[i]) + 1 || bus.gcd_out !== vg[i] || bus.iter_cnt !== vc[i] || bus.err !== 1'b0) begin
                n_bad++;
                $display("FAIL vector_%0d (%0d,%0d): lat=%0d gcd=%0d cnt=%0d err=%b, expected %0d/%0d/%0d/0",
                         i, va[i], vb[i], lat, bus.gcd_out, bus.iter_cnt, bus.err,
                         int'(vc[i]) + 1, vg[i], vc[i]);
            end
            do_ack();
        end
    endtask

    task automatic test_max_iter();
        int lat = -1;
        @(negedge clk);
        bus4.a_in = 8'd255;
        bus4.b_in = 8'd1;
        bus4.go   = 1'b1;
        @(posedge clk);
        #1;
        bus4.go = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (bus4.valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        n_cmp++;
        if (lat != 5 || bus4.gcd_out !== 8'd0 || bus4.err !== 1'b1 || bus4.iter_cnt !== 3'd4) begin
            n_bad++;
            $display("FAIL max_iter: lat=%0d gcd=%0d err=%b cnt=%0d, expected 5/0/1/4",
                     lat, bus4.gcd_out, bus4.err, bus4.iter_cnt);
        end
        @(negedge clk);
        bus4.ack = 1'b1;
        @(posedge clk);
        #1;
        bus4.ack = 1'b0;
    endtask

    task automatic test_abort();
        int lat;
        int seen_valid = 0;
        start_op(8'd200, 8'd3);
        repeat (2) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        n_cmp++;
        if (bus.ready !== 1'b1 || bus.gcd_out !== 8'd0 || bus.iter_cnt !== 8'd0 || bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_clear: ready=%b gcd=%0d cnt=%0d err=%b, expected 1/0/0/0",
                     bus.ready, bus.gcd_out, bus.iter_cnt, bus.err);
        end
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            if (bus.valid !== 1'b0) seen_valid++;
        end
        n_cmp++;
        if (seen_valid != 0) begin
            n_bad++;
            $display("FAIL abort_no_valid: valid seen %0d cycles, expected 0", seen_valid);
        end
        start_op(8'd9, 8'd6);
        wait_valid(lat);
        n_cmp++;
        if (bus.gcd_out !== 8'd3 || bus.iter_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL abort_recover: gcd=%0d cnt=%0d, expected 3/2", bus.gcd_out, bus.iter_cnt);
        end
        do_ack();
    endtask

    task automatic test_async_reset();
        int lat;
        int stray = 0;
        start_op(8'd255, 8'd1);
        repeat (5) @(posedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.ready !== 1'b1 || bus.valid !== 1'b0 || bus.gcd_out !== 8'd0 ||
            bus.iter_cnt !== 8'd0 || bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: ready=%b valid=%b gcd=%0d cnt=%0d err=%b, expected 1/0/0/0/0",
                     bus.ready, bus.valid, bus.gcd_out, bus.iter_cnt, bus.err);
        end
        @(negedge clk);
        clr_n = 1'b1;
        start_op(8'd12, 8'd18);
        wait_valid(lat);
        @(negedge clk);
        bus.a_in = 8'd9;
        bus.b_in = 8'd6;
        bus.go   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.ready !== 1'b0 || bus.gcd_out !== 8'd6 || bus.iter_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL go_in_done: valid=%b ready=%b gcd=%0d cnt=%0d, expected 1/0/6/2",
                     bus.valid, bus.ready, bus.gcd_out, bus.iter_cnt);
        end
        bus.go = 1'b0;
        do_ack();
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            if (bus.ready !== 1'b1 || bus.gcd_out !== 8'd6) stray++;
        end
        n_cmp++;
        if (stray != 0) begin
            n_bad++;
            $display("FAIL go_not_queued: %0d cycles left IDLE or changed result, expected 0", stray);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        start_op(8'd12, 8'd18);
        wait_valid(lat);
        do_ack();
        start_op(8'd9, 8'd6);
        n_cmp++;
        if (bus.ready !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_accept: ready=%b after go, expected 0", bus.ready);
        end
        wait_valid(lat);
        n_cmp++;
        if (lat != 3 || bus.gcd_out !== 8'd3 || bus.iter_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL b2b_result: lat=%0d gcd=%0d cnt=%0d, expected 3/3/2", lat, bus.gcd_out, bus.iter_cnt);
        end
        do_ack();
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_g;
        int lat;
        for (int i = 0; i < 10; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (a == 8'd0 && b == 8'd0) a = 8'd1;
            exp_g = ref_gcd(a, b);
            start_op(a, b);
            wait_valid(lat);
            n_cmp++;
            if (lat < 0 || bus.gcd_out !== exp_g || bus.err !== 1'b0) begin
                n_bad++;
                $display("FAIL random_%0d (%0d,%0d): lat=%0d gcd=%0d err=%b, expected gcd=%0d err=0",
                         i, a, b, lat, bus.gcd_out, bus.err, exp_g);
            end
            do_ack();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_vectors();
        test_max_iter();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
